spi_apb_bridge: RTL and testbench

- SPI slave front end of the GPIO expander; converts 16-bit SPI frames from an external host into single APB transfers.
- Acts as APB master towards the GPIO register block (OE/PU/PD/A/Y registers at addresses 0..4).
- SPI mode 0 only: sample MOSI on SCK rise, change MISO on SCK fall. SCK, CS_N and MOSI are oversampled in the pclk domain.

---
 rtl/spi_apb_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_apb_bridge.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_bridge.sv
// spi_apb_bridge: SPI mode-0 slave that turns 16-bit host frames into single APB transfers.
// Define SPI_APB_TIMEOUT_EN to abort an APB transfer after TIMEOUT_CYC cycles without pready.
module spi_apb_bridge #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    output logic                  busy,
    output logic                  xfer_err
);
    localparam int unsigned FRAME_BITS = 8 + DATA_WIDTH;
    localparam logic [4:0]  CMD_CNT    = 5'd8;
    localparam logic [4:0]  FRAME_CNT  = 5'(FRAME_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DATA, S_SETUP, S_ACCESS, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              sck_sync_q, cs_sync_q;
    logic [1:0]              mosi_sync_q;
    logic                    sck_rise, sck_fall, cs_fall, cs_hi, abort, timeout;
    logic [4:0]              bitcnt_q, bitcnt_d;
    logic [FRAME_BITS-1:0]   rx_q, rx_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d, tx_first;
    logic                    miso_q, miso_d, err_q, err_d;
    logic                    is_rd_q, is_rd_d, rd_valid_q, rd_valid_d, tx_act_q, tx_act_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;

    // cs_n synchronisers reset to the deselected level so reset never looks like a frame start.
    always_ff @(posedge pclk) begin
        if (preset) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], sck};
            cs_sync_q   <= {cs_sync_q[1:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
        end
    end

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_hi    = cs_sync_q[1];
    assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];

`ifdef SPI_APB_TIMEOUT_EN
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYC - 1);
    logic [3:0] wait_q, wait_d;

    always_comb wait_d = (state_q == S_ACCESS) ? wait_q + 4'd1 : '0;

    always_ff @(posedge pclk) begin
        if (preset) wait_q <= '0;
        else        wait_q <= wait_d;
    end

    assign timeout = (state_q == S_ACCESS) && !pready && (wait_q == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            S_IDLE:   if (cs_fall) state_d = S_CMD;
            S_CMD: begin
                if (bitcnt_q == CMD_CNT) state_d = rx_q[7] ? S_DATA : S_SETUP;
                else if (cs_hi) begin
                    state_d = S_IDLE;
                    abort   = 1'b1;
                end
            end
            S_DATA: begin
                if (bitcnt_q == FRAME_CNT) state_d = S_SETUP;
                else if (cs_hi) begin
                    state_d = S_IDLE;
                    abort   = 1'b1;
                end
            end
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (pready || timeout) state_d = (pwrite_q || !cs_hi) ? S_DONE : S_IDLE;
            S_DONE:   if (cs_hi) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        busy    = 1'b1;
        case (state_q)
            S_IDLE:   busy = 1'b0;
            S_SETUP:  psel = 1'b1;
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bitcnt_d   = bitcnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        tx_first   = tx_q;
        miso_d     = miso_q;
        is_rd_d    = is_rd_q;
        rd_valid_d = rd_valid_q;
        tx_act_d   = tx_act_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        err_d      = abort | timeout;

        if (state_q == S_CMD && state_d == S_SETUP) begin
            paddr_d  = rx_q[ADDR_WIDTH-1:0];
            pwrite_d = 1'b0;
            is_rd_d  = 1'b1;
        end
        if (state_q == S_DATA && state_d == S_SETUP) begin
            paddr_d  = rx_q[DATA_WIDTH +: ADDR_WIDTH];
            pwrite_d = rx_q[FRAME_BITS-1];
            pwdata_d = rx_q[DATA_WIDTH-1:0];
        end
        // Read data is captured only if MISO has not already begun shifting the late-read filler.
        if (state_q == S_ACCESS && !pwrite_q && (pready || timeout) && !tx_act_q) begin
            tx_d       = pready ? prdata : '1;
            rd_valid_d = 1'b1;
        end

        if (cs_fall) begin
            bitcnt_d   = '0;
            is_rd_d    = 1'b0;
            rd_valid_d = 1'b0;
            tx_act_d   = 1'b0;
            miso_d     = 1'b0;
        end else if (cs_hi) begin
            miso_d = 1'b0;
        end else begin
            if (sck_rise && bitcnt_q < FRAME_CNT) begin
                bitcnt_d = bitcnt_q + 5'd1;
                rx_d     = {rx_q[FRAME_BITS-2:0], mosi_sync_q[1]};
            end
            if (sck_fall) begin
                miso_d = 1'b0;
                if (is_rd_q && bitcnt_q >= CMD_CNT && bitcnt_q < FRAME_CNT) begin
                    if (!tx_act_q) begin
                        tx_act_d = 1'b1;
                        if (!rd_valid_q) begin
                            tx_first = '1;
                            err_d    = 1'b1;
                        end
                    end
                    miso_d = tx_first[DATA_WIDTH-1];
                    tx_d   = {tx_first[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            bitcnt_q   <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            err_q      <= 1'b0;
            is_rd_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            tx_act_q   <= 1'b0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
        end else begin
            bitcnt_q   <= bitcnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            err_q      <= err_d;
            is_rd_q    <= is_rd_d;
            rd_valid_q <= rd_valid_d;
            tx_act_q   <= tx_act_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = ~cs_hi;
    assign paddr    = paddr_q;
    assign pwrite   = pwrite_q;
    assign pwdata   = pwdata_q;
    assign xfer_err = err_q;

endmodule

// File: tb/tb_spi_apb_bridge.sv
// Directed self-checking bench for spi_apb_bridge: SPI host model, APB responder and bus monitor.
module tb_spi_apb_bridge;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic          pclk = 1'b0, preset = 1'b1, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic          miso, miso_oe, pwrite, psel, penable, pready, busy, xfer_err;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata = '0;

    int checks = 0, errors = 0;
    int ready_mode = 0, ready_cnt = 0;
    int xfers, setup_cycles, en_cycles, psel_cycles, err_pulses, unstable;
    logic [AW-1:0] last_addr, held_addr;
    logic          last_wr, held_wr;
    logic [DW-1:0] last_wdata, held_wdata;
    logic [15:0]   mb;

    spi_apb_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYC(15)) dut (
        .pclk(pclk), .preset(preset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .paddr(paddr), .pwrite(pwrite),
        .psel(psel), .penable(penable), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .busy(busy), .xfer_err(xfer_err)
    );

    always #5 pclk = ~pclk;

    // ready_mode: 0 = tied high, 1 = ready in 4th ACCESS cycle, 2 = stuck low
    assign pready = (ready_mode == 0) || (ready_mode == 1 && ready_cnt >= 3);
    always @(posedge pclk) ready_cnt <= (psel && penable && !pready) ? ready_cnt + 1 : 0;

    always @(negedge pclk) begin
        if (psel && !penable) begin
            setup_cycles++;
            held_addr = paddr; held_wr = pwrite; held_wdata = pwdata;
        end
        if (psel && penable) begin
            en_cycles++;
            if (paddr !== held_addr || pwrite !== held_wr || pwdata !== held_wdata) unstable++;
            if (pready) begin
                xfers++;
                last_addr = paddr; last_wr = pwrite; last_wdata = pwdata;
            end
        end
        if (psel) psel_cycles++;
        if (xfer_err) err_pulses++;
    end

    task automatic clear_counts();
        xfers = 0; setup_cycles = 0; en_cycles = 0; psel_cycles = 0; err_pulses = 0; unstable = 0;
        last_addr = '0; last_wr = 1'b0; last_wdata = '0;
    endtask

    task automatic spi_frame(input logic [15:0] val, input int nbits, input int half,
                             output logic [15:0] bits);
        bits = '0;
        @(negedge pclk); cs_n = 1'b0;
        repeat (half) @(negedge pclk);
        for (int i = 0; i < nbits; i++) begin
            mosi = val[15-i];
            repeat (half) @(negedge pclk);
            bits = {bits[14:0], miso};
            sck = 1'b1;
            repeat (half) @(negedge pclk);
            sck = 1'b0;
        end
        repeat (half) @(negedge pclk);
    endtask

    task automatic cs_up();
        @(negedge pclk); cs_n = 1'b1; mosi = 1'b0;
        repeat (8) @(negedge pclk);
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (3) @(negedge pclk);
        checks++; if (psel !== 1'b0) begin errors++; $display("FAIL reset_psel: got %b expected 0", psel); end
        checks++; if (penable !== 1'b0) begin errors++; $display("FAIL reset_penable: got %b expected 0", penable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (xfer_err !== 1'b0) begin errors++; $display("FAIL reset_xfer_err: got %b expected 0", xfer_err); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe: got %b expected 0", miso_oe); end
        checks++; if (paddr !== 3'd0) begin errors++; $display("FAIL reset_paddr: got %0d expected 0", paddr); end
        checks++; if (pwrite !== 1'b0) begin errors++; $display("FAIL reset_pwrite: got %b expected 0", pwrite); end
        checks++; if (pwdata !== 8'h00) begin errors++; $display("FAIL reset_pwdata: got %h expected 00", pwdata); end
        preset = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    task automatic test_write();
        clear_counts(); ready_mode = 0;
        spi_frame(16'h8155, 16, 8, mb);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_held: got %b expected 1", busy); end
        checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL write_miso_oe: got %b expected 1", miso_oe); end
        checks++; if (mb !== 16'h0000) begin errors++; $display("FAIL write_miso_zero: got %h expected 0000", mb); end
        cs_up();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_fall: got %b expected 0", busy); end
        checks++; if (xfers !== 1) begin errors++; $display("FAIL write_xfers: got %0d expected 1", xfers); end
        checks++; if (last_addr !== 3'd1) begin errors++; $display("FAIL write_paddr: got %0d expected 1", last_addr); end
        checks++; if (last_wr !== 1'b1) begin errors++; $display("FAIL write_pwrite: got %b expected 1", last_wr); end
        checks++; if (last_wdata !== 8'h55) begin errors++; $display("FAIL write_pwdata: got %h expected 55", last_wdata); end
        checks++; if (setup_cycles !== 1) begin errors++; $display("FAIL write_setup_cycles: got %0d expected 1", setup_cycles); end
        checks++; if (en_cycles !== 1) begin errors++; $display("FAIL write_access_cycles: got %0d expected 1", en_cycles); end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL write_xfer_err: got %0d expected 0", err_pulses); end
    endtask

    task automatic test_read();
        clear_counts(); ready_mode = 0; prdata = 8'hA7;
        spi_frame(16'h0300, 16, 8, mb);
        cs_up();
        checks++; if (xfers !== 1) begin errors++; $display("FAIL read_xfers: got %0d expected 1", xfers); end
        checks++; if (last_addr !== 3'd3) begin errors++; $display("FAIL read_paddr: got %0d expected 3", last_addr); end
        checks++; if (last_wr !== 1'b0) begin errors++; $display("FAIL read_pwrite: got %b expected 0", last_wr); end
        checks++; if (mb[7:0] !== 8'hA7) begin errors++; $display("FAIL read_miso_data: got %h expected a7", mb[7:0]); end
        checks++; if (mb[15:8] !== 8'h00) begin errors++; $display("FAIL read_miso_cmd: got %h expected 00", mb[15:8]); end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL read_xfer_err: got %0d expected 0", err_pulses); end
    endtask

    task automatic test_wait_states();
        clear_counts(); ready_mode = 1;
        spi_frame(16'h8233, 16, 8, mb);
        cs_up();
        ready_mode = 0;
        checks++; if (en_cycles !== 4) begin errors++; $display("FAIL wait_penable_cycles: got %0d expected 4", en_cycles); end
        checks++; if (setup_cycles !== 1) begin errors++; $display("FAIL wait_setup_cycles: got %0d expected 1", setup_cycles); end
        checks++; if (xfers !== 1) begin errors++; $display("FAIL wait_xfers: got %0d expected 1", xfers); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL wait_stable: got %0d changes expected 0", unstable); end
        checks++; if (last_addr !== 3'd2) begin errors++; $display("FAIL wait_paddr: got %0d expected 2", last_addr); end
        checks++; if (last_wdata !== 8'h33) begin errors++; $display("FAIL wait_pwdata: got %h expected 33", last_wdata); end
    endtask

    task automatic test_abort();
        clear_counts(); ready_mode = 0;
        spi_frame(16'h8000, 10, 8, mb);
        cs_up();
        checks++; if (psel_cycles !== 0) begin errors++; $display("FAIL abort_psel: got %0d cycles expected 0", psel_cycles); end
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL abort_xfer_err: got %0d expected 1", err_pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        spi_frame(16'h8011, 16, 8, mb);
        cs_up();
        checks++; if (xfers !== 1) begin errors++; $display("FAIL abort_next_xfers: got %0d expected 1", xfers); end
        checks++; if (last_addr !== 3'd0) begin errors++; $display("FAIL abort_next_paddr: got %0d expected 0", last_addr); end
        checks++; if (last_wdata !== 8'h11) begin errors++; $display("FAIL abort_next_pwdata: got %h expected 11", last_wdata); end
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL abort_next_err: got %0d expected 1", err_pulses); end
    endtask

    task automatic test_reset_in_access();
        clear_counts(); ready_mode = 2;
        spi_frame(16'h8477, 16, 8, mb);
        checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rst_access_reached: got %b expected 1", penable); end
        preset = 1'b1; cs_n = 1'b1; mosi = 1'b0;
        @(negedge pclk);
        checks++; if (psel !== 1'b0) begin errors++; $display("FAIL rst_access_psel: got %b expected 0", psel); end
        checks++; if (penable !== 1'b0) begin errors++; $display("FAIL rst_access_penable: got %b expected 0", penable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_access_busy: got %b expected 0", busy); end
        preset = 1'b0; ready_mode = 0;
        clear_counts();
        repeat (40) @(negedge pclk);
        checks++; if (psel_cycles !== 0) begin errors++; $display("FAIL rst_access_quiet: got %0d psel cycles expected 0", psel_cycles); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_access_idle: got %b expected 0", busy); end
    endtask

`ifdef SPI_APB_TIMEOUT_EN
    task automatic test_timeout();
        clear_counts(); ready_mode = 2; prdata = 8'h5A;
        spi_frame(16'h0100, 16, 32, mb);
        cs_up();
        ready_mode = 0;
        checks++; if (en_cycles !== 15) begin errors++; $display("FAIL timeout_access_cycles: got %0d expected 15", en_cycles); end
        checks++; if (xfers !== 0) begin errors++; $display("FAIL timeout_xfers: got %0d expected 0", xfers); end
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL timeout_xfer_err: got %0d expected 1", err_pulses); end
        checks++; if (mb[7:0] !== 8'hFF) begin errors++; $display("FAIL timeout_miso: got %h expected ff", mb[7:0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
    endtask
`endif

    initial begin
        clear_counts();
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_abort();
        test_reset_in_access();
`ifdef SPI_APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
